// File: rtl/nes_bus_pkg.sv
// Shared types and address map for the NES CPU-side bus controller.
package nes_bus_pkg;

    typedef enum logic [1:0] {
        REG_RAM,
        REG_PPU,
        REG_IO,
        REG_CART
    } region_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HALT,
        ST_ALIGN,
        ST_READ,
        ST_WRITE
    } dma_state_t;

    localparam logic [15:0] PPU_BASE       = 16'h2000;
    localparam logic [15:0] IO_BASE        = 16'h4000;
    localparam logic [15:0] DMA_REG_ADDR   = 16'h4014;
    localparam logic [15:0] CART_BASE_ADDR = 16'h4020;

endpackage

// File: rtl/nes_bus_if.sv
// CPU, slave and status signals of the NES bus controller.
// The slave modport is the controller's view, master is the CPU/memory side.
interface nes_bus_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8,
    parameter int RAM_AW = 11,
    parameter int PPU_AW = 3
);
    logic [ADDR_W-1:0] CPU_ADDR;
    logic [DATA_W-1:0] CPU_DATA_OUT;
    logic              CPU_RW_n;
    logic [DATA_W-1:0] CPU_DATA_IN;
    logic              CPU_ENABLE;
    logic [RAM_AW-1:0] RAM_ADDR;
    logic [DATA_W-1:0] RAM_DATA_IN;
    logic              RAM_WREN;
    logic              RAM_RDEN;
    logic [DATA_W-1:0] RAM_DATA_OUT;
    logic [PPU_AW-1:0] PPU_ADDR;
    logic [DATA_W-1:0] PPU_DATA_IN;
    logic              PPU_WREN;
    logic              PPU_RDEN;
    logic [DATA_W-1:0] PPU_DATA_OUT;
    logic [ADDR_W-1:0] CART_ADDR;
    logic              CART_RDEN;
    logic [DATA_W-1:0] CART_DATA_OUT;
    logic              DMA_BUSY;

    modport slave (
        input  CPU_ADDR, CPU_DATA_OUT, CPU_RW_n,
        input  RAM_DATA_OUT, PPU_DATA_OUT, CART_DATA_OUT,
        output CPU_DATA_IN, CPU_ENABLE,
        output RAM_ADDR, RAM_DATA_IN, RAM_WREN, RAM_RDEN,
        output PPU_ADDR, PPU_DATA_IN, PPU_WREN, PPU_RDEN,
        output CART_ADDR, CART_RDEN, DMA_BUSY
    );

    modport master (
        output CPU_ADDR, CPU_DATA_OUT, CPU_RW_n,
        output RAM_DATA_OUT, PPU_DATA_OUT, CART_DATA_OUT,
        input  CPU_DATA_IN, CPU_ENABLE,
        input  RAM_ADDR, RAM_DATA_IN, RAM_WREN, RAM_RDEN,
        input  PPU_ADDR, PPU_DATA_IN, PPU_WREN, PPU_RDEN,
        input  CART_ADDR, CART_RDEN, DMA_BUSY
    );
endinterface

// File: rtl/nes_oam_dma.sv
// OAM DMA engine: halts the CPU and copies one page into the PPU OAM data register.
module nes_oam_dma
    import nes_bus_pkg::*;
#(
    parameter int                 ADDR_W       = 16,
    parameter int                 DATA_W       = 8,
    parameter int                 PPU_AW       = 3,
    parameter logic [ADDR_W-1:0]  DMA_REG      = DMA_REG_ADDR,
    parameter logic [PPU_AW-1:0]  OAM_DATA_IDX = 3'd4,
    parameter int                 DMA_LEN      = 256
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cpu_wr,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [ADDR_W-1:0] dma_addr,
    output logic              dma_rd,
    output logic              dma_wr,
    output logic              dma_own,
    output logic              cpu_enable,
    output logic              dma_busy
);
    localparam int IDX_W = $clog2(DMA_LEN);

    dma_state_t        state, state_nxt;
    logic              parity;
    logic              trig_p1;
    logic              trig_hit;
    logic [DATA_W-1:0] page;
    logic [IDX_W-1:0]  idx;

    // Only one trigger is accepted per idle period; later writes are dropped.
    assign trig_hit = cpu_wr && (cpu_addr == DMA_REG) && (state == ST_IDLE) && !trig_p1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            parity  <= 1'b0;
            trig_p1 <= 1'b0;
            page    <= '0;
            idx     <= '0;
        end else begin
            parity  <= ~parity;
            trig_p1 <= trig_hit;
            if (trig_hit)
                page <= cpu_wdata;
            if (state == ST_IDLE && state_nxt == ST_HALT)
                idx <= '0;
            else if (state == ST_WRITE)
                idx <= idx + 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (trig_p1) state_nxt = ST_HALT;
            ST_HALT:  state_nxt = parity ? ST_ALIGN : ST_READ;
            ST_ALIGN: state_nxt = ST_READ;
            ST_READ:  state_nxt = ST_WRITE;
            ST_WRITE: state_nxt = (idx == IDX_W'(DMA_LEN - 1)) ? ST_IDLE : ST_READ;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        dma_addr   = '0;
        dma_rd     = 1'b0;
        dma_wr     = 1'b0;
        dma_own    = 1'b0;
        cpu_enable = 1'b0;
        dma_busy   = 1'b1;
        case (state)
            ST_IDLE: begin
                cpu_enable = 1'b1;
                dma_busy   = 1'b0;
            end
            ST_HALT: ;
            ST_ALIGN: dma_own = 1'b1;
            ST_READ: begin
                dma_own  = 1'b1;
                dma_rd   = 1'b1;
                dma_addr = ADDR_W'({page, idx});
            end
            ST_WRITE: begin
                dma_own  = 1'b1;
                dma_wr   = 1'b1;
                dma_addr = ADDR_W'(PPU_BASE) | ADDR_W'(OAM_DATA_IDX);
            end
            default: begin
                cpu_enable = 1'b1;
                dma_busy   = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/nes_bus_ctrl.sv
// NES CPU-side bus controller: address decode, mirroring, read return and OAM DMA.
// Define NES_BUS_OPEN_BUS_EN to keep an open-bus latch; otherwise unmapped reads return 8'hAA.
module nes_bus_ctrl
    import nes_bus_pkg::*;
#(
    parameter int                ADDR_W       = 16,
    parameter int                DATA_W       = 8,
    parameter int                RAM_AW       = 11,
    parameter int                PPU_AW       = 3,
    parameter logic [ADDR_W-1:0] CART_BASE    = CART_BASE_ADDR,
    parameter logic [ADDR_W-1:0] DMA_REG      = DMA_REG_ADDR,
    parameter logic [PPU_AW-1:0] OAM_DATA_IDX = 3'd4,
    parameter int                DMA_LEN      = 256
) (
    input  logic    CLK,
    input  logic    RESET_n,
    nes_bus_if.slave bus
);
    logic [ADDR_W-1:0] m_addr, dma_addr;
    logic [DATA_W-1:0] m_wdata, rdata, ob_val;
    logic              m_rd, m_wr, dma_rd, dma_wr, dma_own, cpu_wr;
    region_t           m_reg, sel_p1;
    logic              vld_p1;

    function automatic region_t decode(input logic [ADDR_W-1:0] a);
        if (a < ADDR_W'(PPU_BASE))     return REG_RAM;
        else if (a < ADDR_W'(IO_BASE)) return REG_PPU;
        else if (a < CART_BASE)        return REG_IO;
        else                           return REG_CART;
    endfunction

    assign cpu_wr = !dma_own && !bus.CPU_RW_n;

    nes_oam_dma #(
        .ADDR_W       (ADDR_W),
        .DATA_W       (DATA_W),
        .PPU_AW       (PPU_AW),
        .DMA_REG      (DMA_REG),
        .OAM_DATA_IDX (OAM_DATA_IDX),
        .DMA_LEN      (DMA_LEN)
    ) u_dma (
        .clk        (CLK),
        .rst_n      (RESET_n),
        .cpu_wr     (cpu_wr),
        .cpu_addr   (bus.CPU_ADDR),
        .cpu_wdata  (bus.CPU_DATA_OUT),
        .dma_addr   (dma_addr),
        .dma_rd     (dma_rd),
        .dma_wr     (dma_wr),
        .dma_own    (dma_own),
        .cpu_enable (bus.CPU_ENABLE),
        .dma_busy   (bus.DMA_BUSY)
    );

    // DMA writes forward the byte returned by its preceding read.
    always_comb begin
        if (dma_own) begin
            m_addr  = dma_addr;
            m_rd    = dma_rd;
            m_wr    = dma_wr;
            m_wdata = rdata;
        end else begin
            m_addr  = bus.CPU_ADDR;
            m_rd    = bus.CPU_RW_n;
            m_wr    = !bus.CPU_RW_n;
            m_wdata = bus.CPU_DATA_OUT;
        end
        m_reg = decode(m_addr);
    end

    assign bus.RAM_ADDR    = m_addr[RAM_AW-1:0];
    assign bus.RAM_DATA_IN = m_wdata;
    assign bus.RAM_WREN    = m_wr && (m_reg == REG_RAM);
    assign bus.RAM_RDEN    = m_rd && (m_reg == REG_RAM);
    assign bus.PPU_ADDR    = m_addr[PPU_AW-1:0];
    assign bus.PPU_DATA_IN = m_wdata;
    assign bus.PPU_WREN    = m_wr && (m_reg == REG_PPU);
    assign bus.PPU_RDEN    = m_rd && (m_reg == REG_PPU);
    assign bus.CART_ADDR   = m_addr;
    assign bus.CART_RDEN   = m_rd && (m_reg == REG_CART);

    // Stage p1: region of the access whose slave data returns this cycle.
    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            sel_p1 <= REG_IO;
            vld_p1 <= 1'b0;
        end else begin
            sel_p1 <= m_reg;
            vld_p1 <= m_rd;
        end
    end

`ifdef NES_BUS_OPEN_BUS_EN
    logic [DATA_W-1:0] open_bus;

    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n)    open_bus <= '0;
        else if (cpu_wr) open_bus <= bus.CPU_DATA_OUT;
        else if (vld_p1) open_bus <= rdata;
    end

    assign ob_val = open_bus;
`else
    assign ob_val = DATA_W'(8'hAA);
`endif

    // Cycles without a returning read present zero rather than stale slave data.
    always_comb begin
        rdata = '0;
        if (vld_p1) begin
            case (sel_p1)
                REG_RAM:  rdata = bus.RAM_DATA_OUT;
                REG_PPU:  rdata = bus.PPU_DATA_OUT;
                REG_CART: rdata = bus.CART_DATA_OUT;
                default:  rdata = ob_val;
            endcase
        end
    end

    assign bus.CPU_DATA_IN = rdata;

endmodule

// File: tb/tb_nes_bus_ctrl.sv
// Directed testbench for nes_bus_ctrl: decode, mirroring, read return, open bus and OAM DMA.
module tb_nes_bus_ctrl;
    import nes_bus_pkg::*;

`ifdef NES_BUS_OPEN_BUS_EN
    localparam bit OB_EN = 1'b1;
`else
    localparam bit OB_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    nes_bus_if #(.ADDR_W(16), .DATA_W(8), .RAM_AW(11), .PPU_AW(3)) bus ();

    nes_bus_ctrl dut (
        .CLK     (clk),
        .RESET_n (rst_n),
        .bus     (bus)
    );

    int total = 0;
    int bad   = 0;

    logic [7:0] ram_mem [0:2047];
    always @(posedge clk) begin
        if (bus.RAM_WREN) ram_mem[bus.RAM_ADDR] <= bus.RAM_DATA_IN;
        if (bus.RAM_RDEN) bus.RAM_DATA_OUT <= ram_mem[bus.RAM_ADDR];
        if (bus.PPU_RDEN) bus.PPU_DATA_OUT <= 8'h30 + {5'd0, bus.PPU_ADDR};
        if (bus.CART_RDEN) bus.CART_DATA_OUT <= bus.CART_ADDR[7:0] ^ 8'h3C;
    end

    // Expected cycle parity: cleared by reset, toggles on every edge.
    logic par_m;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) par_m <= 1'b0;
        else        par_m <= ~par_m;
    end

    int         ppu_wr_cnt = 0;
    int         halt_cnt   = 0;
    logic [7:0] wr_data [0:255];
    logic [2:0] wr_idx  [0:255];
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.PPU_WREN) begin
                wr_data[ppu_wr_cnt[7:0]] = bus.PPU_DATA_IN;
                wr_idx[ppu_wr_cnt[7:0]]  = bus.PPU_ADDR;
                ppu_wr_cnt++;
            end
            if (!bus.CPU_ENABLE) halt_cnt++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cpu_rd(input logic [15:0] a);
        bus.CPU_ADDR     = a;
        bus.CPU_RW_n     = 1'b1;
        bus.CPU_DATA_OUT = 8'h00;
    endtask

    task automatic cpu_wr(input logic [15:0] a, input logic [7:0] d);
        bus.CPU_ADDR     = a;
        bus.CPU_RW_n     = 1'b0;
        bus.CPU_DATA_OUT = d;
    endtask

    task automatic test_reset();
        logic [4:0] strb;
        cpu_rd(16'h4000);
        rst_n = 1'b0;
        repeat (3) tick();
        strb = {bus.RAM_WREN, bus.RAM_RDEN, bus.PPU_WREN, bus.PPU_RDEN, bus.CART_RDEN};
        total++; if (bus.CPU_ENABLE !== 1'b1) begin bad++; $display("FAIL reset_cpu_enable got=%b want=1", bus.CPU_ENABLE); end
        total++; if (bus.DMA_BUSY !== 1'b0) begin bad++; $display("FAIL reset_dma_busy got=%b want=0", bus.DMA_BUSY); end
        total++; if (bus.CPU_DATA_IN !== 8'h00) begin bad++; $display("FAIL reset_data_in got=%h want=00", bus.CPU_DATA_IN); end
        total++; if (strb !== 5'b0) begin bad++; $display("FAIL reset_strobes got=%b want=00000", strb); end
        rst_n = 1'b1;
        #1;
        total++; if (bus.CPU_DATA_IN !== 8'h00) begin bad++; $display("FAIL release_data_in got=%h want=00", bus.CPU_DATA_IN); end
        tick();
        total++; if (bus.CPU_DATA_IN !== (OB_EN ? 8'h00 : 8'hAA)) begin bad++; $display("FAIL reset_open_bus got=%h want=%h", bus.CPU_DATA_IN, OB_EN ? 8'h00 : 8'hAA); end
    endtask

    task automatic test_ram_mirror();
        tick();
        cpu_wr(16'h0805, 8'h5A);
        #1;
        total++; if ({bus.RAM_WREN, bus.RAM_RDEN} !== 2'b10) begin bad++; $display("FAIL ram_wr_strobes got=%b want=10", {bus.RAM_WREN, bus.RAM_RDEN}); end
        total++; if (bus.RAM_ADDR !== 11'h005) begin bad++; $display("FAIL ram_wr_addr got=%h want=005", bus.RAM_ADDR); end
        total++; if (bus.RAM_DATA_IN !== 8'h5A) begin bad++; $display("FAIL ram_wr_data got=%h want=5a", bus.RAM_DATA_IN); end
        tick();
        cpu_rd(16'h0005);
        #1;
        total++; if (bus.RAM_RDEN !== 1'b1 || bus.RAM_ADDR !== 11'h005) begin bad++; $display("FAIL ram_rd got=%b/%h want=1/005", bus.RAM_RDEN, bus.RAM_ADDR); end
        tick();
        cpu_rd(16'h1FFF);
        #1;
        total++; if (bus.CPU_DATA_IN !== 8'h5A) begin bad++; $display("FAIL ram_rd_data got=%h want=5a", bus.CPU_DATA_IN); end
        total++; if (bus.RAM_ADDR !== 11'h7FF || bus.RAM_RDEN !== 1'b1) begin bad++; $display("FAIL ram_top_edge got=%h/%b want=7ff/1", bus.RAM_ADDR, bus.RAM_RDEN); end
        tick();
        cpu_rd(16'h2000);
        #1;
        total++; if ({bus.RAM_RDEN, bus.PPU_RDEN, bus.PPU_ADDR} !== 5'b01000) begin bad++; $display("FAIL ppu_low_edge got=%b want=01000", {bus.RAM_RDEN, bus.PPU_RDEN, bus.PPU_ADDR}); end
    endtask

    task automatic test_ppu_mirror();
        tick();
        cpu_rd(16'h3FFA);
        #1;
        total++; if (bus.PPU_RDEN !== 1'b1 || bus.PPU_ADDR !== 3'd2) begin bad++; $display("FAIL ppu_rd got=%b/%0d want=1/2", bus.PPU_RDEN, bus.PPU_ADDR); end
        tick();
        cpu_wr(16'h2001, 8'h77);
        #1;
        total++; if (bus.CPU_DATA_IN !== 8'h32) begin bad++; $display("FAIL ppu_rd_data got=%h want=32", bus.CPU_DATA_IN); end
        total++; if ({bus.PPU_WREN, bus.PPU_RDEN, bus.PPU_ADDR} !== 5'b10001 || bus.PPU_DATA_IN !== 8'h77) begin bad++; $display("FAIL ppu_wr got=%b/%h want=10001/77", {bus.PPU_WREN, bus.PPU_RDEN, bus.PPU_ADDR}, bus.PPU_DATA_IN); end
    endtask

    task automatic test_cart_io();
        logic [4:0] strb;
        tick();
        cpu_rd(16'h8123);
        #1;
        total++; if (bus.CART_RDEN !== 1'b1 || bus.CART_ADDR !== 16'h8123) begin bad++; $display("FAIL cart_rd got=%b/%h want=1/8123", bus.CART_RDEN, bus.CART_ADDR); end
        tick();
        cpu_wr(16'h8000, 8'hC3);
        #1;
        strb = {bus.RAM_WREN, bus.RAM_RDEN, bus.PPU_WREN, bus.PPU_RDEN, bus.CART_RDEN};
        total++; if (bus.CPU_DATA_IN !== 8'h1F) begin bad++; $display("FAIL cart_rd_data got=%h want=1f", bus.CPU_DATA_IN); end
        total++; if (strb !== 5'b0) begin bad++; $display("FAIL cart_wr_dropped got=%b want=00000", strb); end
        tick();
        cpu_rd(16'h401F);
        #1;
        strb = {bus.RAM_WREN, bus.RAM_RDEN, bus.PPU_WREN, bus.PPU_RDEN, bus.CART_RDEN};
        total++; if (strb !== 5'b0) begin bad++; $display("FAIL io_top_edge got=%b want=00000", strb); end
        tick();
        cpu_rd(16'h4020);
        #1;
        total++; if (bus.CART_RDEN !== 1'b1) begin bad++; $display("FAIL cart_low_edge got=%b want=1", bus.CART_RDEN); end
        total++; if (bus.CPU_DATA_IN !== (OB_EN ? 8'hC3 : 8'hAA)) begin bad++; $display("FAIL open_bus_wr_datum got=%h want=%h", bus.CPU_DATA_IN, OB_EN ? 8'hC3 : 8'hAA); end
        tick();
        cpu_rd(16'h4000);
        #1;
        total++; if (bus.CPU_DATA_IN !== 8'h1C) begin bad++; $display("FAIL cart_edge_data got=%h want=1c", bus.CPU_DATA_IN); end
    endtask

    task automatic test_open_bus();
        tick();
        cpu_rd(16'h0005);
        tick();
        cpu_rd(16'h4000);
        #1;
        total++; if (bus.CPU_DATA_IN !== 8'h5A) begin bad++; $display("FAIL ob_ram_data got=%h want=5a", bus.CPU_DATA_IN); end
        tick();
        total++; if (bus.CPU_DATA_IN !== (OB_EN ? 8'h5A : 8'hAA)) begin bad++; $display("FAIL ob_first got=%h want=%h", bus.CPU_DATA_IN, OB_EN ? 8'h5A : 8'hAA); end
        tick();
        total++; if (bus.CPU_DATA_IN !== (OB_EN ? 8'h5A : 8'hAA)) begin bad++; $display("FAIL ob_hold got=%h want=%h", bus.CPU_DATA_IN, OB_EN ? 8'h5A : 8'hAA); end
    endtask

    task automatic preload_ram();
        for (int i = 0; i < 256; i++) begin
            tick();
            cpu_wr(16'h0200 + 16'(i), 8'(i) ^ 8'hFF);
        end
        tick();
        cpu_rd(16'h0000);
    endtask

    task automatic do_dma(input logic want_par, output bit done, output int halt,
                          output int nwr, output int errs);
        int  base_w, base_h, n;
        bit  seen;
        cpu_rd(16'h0000);
        n = 0;
        while (par_m !== want_par && n < 4) begin
            tick();
            n++;
        end
        base_w = ppu_wr_cnt;
        base_h = halt_cnt;
        cpu_wr(16'h4014, 8'h02);
        tick();
        cpu_rd(16'h0000);
        seen = 1'b0;
        done = 1'b0;
        for (int c = 0; c < 1000 && !done; c++) begin
            tick();
            if (!bus.CPU_ENABLE) seen = 1'b1;
            else if (seen)       done = 1'b1;
        end
        halt = halt_cnt - base_h;
        nwr  = ppu_wr_cnt - base_w;
        errs = 0;
        for (int k = 0; k < nwr && k < 256; k++) begin
            int j = (base_w + k) % 256;
            if (wr_data[j] !== 8'(8'hFF - k) || wr_idx[j] !== 3'd4) errs++;
        end
    endtask

    task automatic test_dma_even();
        bit done; int halt, nwr, errs;
        do_dma(1'b0, done, halt, nwr, errs);
        total++; if (!done) begin bad++; $display("FAIL dma_even_timeout got=running want=finished"); end
        total++; if (halt !== 513) begin bad++; $display("FAIL dma_even_halt got=%0d want=513", halt); end
        total++; if (nwr !== 256) begin bad++; $display("FAIL dma_even_writes got=%0d want=256", nwr); end
        total++; if (errs !== 0) begin bad++; $display("FAIL dma_even_data got=%0d bad bytes want=0", errs); end
        total++; if (bus.DMA_BUSY !== 1'b0) begin bad++; $display("FAIL dma_even_busy_end got=%b want=0", bus.DMA_BUSY); end
    endtask

    task automatic test_dma_odd();
        bit done; int halt, nwr, errs;
        do_dma(1'b1, done, halt, nwr, errs);
        total++; if (!done) begin bad++; $display("FAIL dma_odd_timeout got=running want=finished"); end
        total++; if (halt !== 514) begin bad++; $display("FAIL dma_odd_halt got=%0d want=514", halt); end
        total++; if (nwr !== 256) begin bad++; $display("FAIL dma_odd_writes got=%0d want=256", nwr); end
        total++; if (errs !== 0) begin bad++; $display("FAIL dma_odd_data got=%0d bad bytes want=0", errs); end
    endtask

    task automatic test_abort();
        int base, n;
        tick();
        cpu_rd(16'h0000);
        base = ppu_wr_cnt;
        cpu_wr(16'h4014, 8'h02);
        tick();
        cpu_rd(16'h0000);
        n = 0;
        while ((ppu_wr_cnt - base) < 100 && n < 600) begin
            tick();
            n++;
        end
        total++; if ((ppu_wr_cnt - base) !== 100) begin bad++; $display("FAIL abort_reach_idx got=%0d want=100", ppu_wr_cnt - base); end
        total++; if ({bus.DMA_BUSY, bus.CPU_ENABLE} !== 2'b10) begin bad++; $display("FAIL abort_busy_before got=%b want=10", {bus.DMA_BUSY, bus.CPU_ENABLE}); end
        rst_n = 1'b0;
        #1;
        total++; if ({bus.DMA_BUSY, bus.CPU_ENABLE} !== 2'b01) begin bad++; $display("FAIL abort_immediate got=%b want=01", {bus.DMA_BUSY, bus.CPU_ENABLE}); end
        tick();
        tick();
        rst_n = 1'b1;
        base = ppu_wr_cnt;
        repeat (20) tick();
        total++; if (ppu_wr_cnt !== base) begin bad++; $display("FAIL abort_no_ppu_wr got=%0d want=0", ppu_wr_cnt - base); end
        total++; if ({bus.DMA_BUSY, bus.CPU_ENABLE} !== 2'b01) begin bad++; $display("FAIL abort_after got=%b want=01", {bus.DMA_BUSY, bus.CPU_ENABLE}); end
    endtask

    initial begin
        rst_n = 1'b0;
        cpu_rd(16'h4000);
        test_reset();
        test_ram_mirror();
        test_ppu_mirror();
        test_cart_io();
        test_open_bus();
        preload_ram();
        test_dma_even();
        test_dma_odd();
        test_abort();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
